// File: rtl/alu_result_stage.sv
// alu_result_stage
// Registered result-select stage at the ALU output. One of NUM_IN lane
// results is chosen by sel at accept time and queued in a two-entry skid
// buffer (main + skid) with valid/ready handshakes on both sides. The
// NZCV flag register is updated in accept order, and selects that fall
// outside the populated lanes are passed through as zero with an error bit.
//
// Ports:
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   in_valid     upstream offers a beat
//   in_ready     stage can accept (registered, = !skid full)
//   in_data      NUM_IN concatenated lane results, lane i at [i*WIDTH +: WIDTH]
//   sel          lane select sampled with the beat
//   set_flags    update NZCV from this beat
//   carry_in     adder carry-out for this beat
//   ovf_in       adder signed overflow for this beat
//   out_valid    out_data holds a valid entry
//   out_ready    downstream consumes the entry
//   out_data     selected result of the head entry
//   out_sel_err  head entry's select was out of range
//   flag_n/z/c/v architectural flags (registered)
module alu_result_stage #(
    parameter int WIDTH  = 64,
    parameter int NUM_IN = 5,
    parameter int SEL_W  = 3
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    set_flags,
    input  logic                    carry_in,
    input  logic                    ovf_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_sel_err,
    output logic                    flag_n,
    output logic                    flag_z,
    output logic                    flag_c,
    output logic                    flag_v
);

    localparam int NLANE = 2 ** SEL_W;
    localparam logic [SEL_W:0] NUM_IN_W = NUM_IN[SEL_W:0];

    // Lane table padded to the full select range; unpopulated slots read zero.
    logic [WIDTH-1:0] lane_arr [NLANE];

    genvar gi;
    generate
        for (gi = 0; gi < NLANE; gi++) begin : g_lane
            if (gi < NUM_IN) begin : g_used
                assign lane_arr[gi] = in_data[gi*WIDTH +: WIDTH];
            end else begin : g_pad
                assign lane_arr[gi] = '0;
            end
        end
    endgenerate

    logic             sel_err;
    logic [WIDTH-1:0] sel_data;

    assign sel_err  = ({1'b0, sel} >= NUM_IN_W);
    assign sel_data = sel_err ? '0 : lane_arr[sel];

    logic             main_valid_reg;
    logic [WIDTH-1:0] main_data_reg;
    logic             main_err_reg;
    logic             skid_valid_reg;
    logic [WIDTH-1:0] skid_data_reg;
    logic             skid_err_reg;
    logic             flag_n_reg, flag_z_reg, flag_c_reg, flag_v_reg;

    logic accept;
    logic pop;

    assign in_ready    = !skid_valid_reg;
    assign accept      = in_valid && in_ready;
    assign pop         = main_valid_reg && out_ready;

    assign out_valid   = main_valid_reg;
    assign out_data    = main_data_reg;
    assign out_sel_err = main_err_reg;
    assign flag_n      = flag_n_reg;
    assign flag_z      = flag_z_reg;
    assign flag_c      = flag_c_reg;
    assign flag_v      = flag_v_reg;

    // Entry storage. A full skid implies in_ready = 0, so the skid-to-main
    // transfer never coincides with an accept.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            main_valid_reg <= 1'b0;
            main_data_reg  <= '0;
            main_err_reg   <= 1'b0;
            skid_valid_reg <= 1'b0;
            skid_data_reg  <= '0;
            skid_err_reg   <= 1'b0;
        end else begin
            if (pop && skid_valid_reg) begin
                main_data_reg  <= skid_data_reg;
                main_err_reg   <= skid_err_reg;
                skid_valid_reg <= 1'b0;
            end else if (accept && (!main_valid_reg || pop)) begin
                main_valid_reg <= 1'b1;
                main_data_reg  <= sel_data;
                main_err_reg   <= sel_err;
            end else if (accept) begin
                skid_valid_reg <= 1'b1;
                skid_data_reg  <= sel_data;
                skid_err_reg   <= sel_err;
            end else if (pop) begin
                main_valid_reg <= 1'b0;
            end
        end
    end

    // Flags follow accept order, so downstream stalls never reorder them.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flag_n_reg <= 1'b0;
            flag_z_reg <= 1'b0;
            flag_c_reg <= 1'b0;
            flag_v_reg <= 1'b0;
        end else if (accept && set_flags && !sel_err) begin
            flag_n_reg <= sel_data[WIDTH-1];
            flag_z_reg <= (sel_data == '0);
            flag_c_reg <= carry_in;
            flag_v_reg <= ovf_in;
        end
    end

endmodule

// File: tb/tb_alu_result_stage.sv
module tb_alu_result_stage;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         in_valid, in_ready;
    logic [319:0] in_data;
    logic [2:0]   sel;
    logic         set_flags, carry_in, ovf_in;
    logic         out_valid, out_ready, out_sel_err;
    logic [63:0]  out_data;
    logic         flag_n, flag_z, flag_c, flag_v;

    logic         in_valid16, in_ready16;
    logic [127:0] in_data16;
    logic [2:0]   sel16;
    logic         out_valid16, out_ready16, out_sel_err16;
    logic [15:0]  out_data16;
    logic         fn16, fz16, fc16, fv16;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    alu_result_stage dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .sel(sel),
        .set_flags(set_flags), .carry_in(carry_in), .ovf_in(ovf_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sel_err(out_sel_err),
        .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v)
    );

    alu_result_stage #(.WIDTH(16), .NUM_IN(8), .SEL_W(3)) dut16 (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid16), .in_ready(in_ready16), .in_data(in_data16), .sel(sel16),
        .set_flags(1'b0), .carry_in(1'b0), .ovf_in(1'b0),
        .out_valid(out_valid16), .out_ready(out_ready16), .out_data(out_data16),
        .out_sel_err(out_sel_err16),
        .flag_n(fn16), .flag_z(fz16), .flag_c(fc16), .flag_v(fv16)
    );

    typedef struct {
        logic [2:0]  sel;
        logic [63:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic chk_flags(input string name, input logic [3:0] exp_nzcv);
        chk(name, {60'd0, flag_n, flag_z, flag_c, flag_v}, {60'd0, exp_nzcv});
    endtask

    task automatic set_lanes(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                             input logic [63:0] d, input logic [63:0] e);
        in_data = {e, d, c, b, a};
    endtask

    task automatic step_sample;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        in_valid = 0; in_data = '0; sel = 0; set_flags = 0; carry_in = 0; ovf_in = 0; out_ready = 1;
        in_valid16 = 0; in_data16 = '0; sel16 = 0; out_ready16 = 1;

        vecs[0] = '{3'd0, 64'd2, 1'b0};
        vecs[1] = '{3'd1, 64'd1, 1'b0};
        vecs[2] = '{3'd2, 64'd3, 1'b0};
        vecs[3] = '{3'd3, 64'd4, 1'b0};
        vecs[4] = '{3'd4, 64'd5, 1'b0};
        vecs[5] = '{3'd5, 64'd0, 1'b1};
        vecs[6] = '{3'd6, 64'd0, 1'b1};
        vecs[7] = '{3'd7, 64'd0, 1'b1};

        // reset state
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_in_ready", in_ready, 1);
        chk_flags("rst_flags", 4'b0000);
        @(negedge clk);
        reset_n = 1'b1;

        // select sweep
        set_lanes(64'd2, 64'd1, 64'd3, 64'd4, 64'd5);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            in_valid = 1; sel = vecs[i].sel;
            step_sample();
            $display("sweep sel=%0d data=%0h err=%0b", vecs[i].sel, out_data, out_sel_err);
            chk("sweep_valid", out_valid, 1);
            chk("sweep_data", out_data, vecs[i].exp_data);
            chk("sweep_err", out_sel_err, vecs[i].exp_err);
        end
        @(negedge clk);
        in_valid = 0;
        step_sample();
        chk("sweep_drain", out_valid, 0);

        // backpressure: A, B, C on ADD lane
        @(negedge clk);
        out_ready = 0; in_valid = 1; sel = 0;
        set_lanes(64'hA, 64'd0, 64'd0, 64'd0, 64'd0);
        step_sample();
        $display("bp offer A in_ready=%0b out=%0h", in_ready, out_data);
        chk("bp_a_data", out_data, 64'hA);
        chk("bp_a_ready", in_ready, 1);
        @(negedge clk);
        set_lanes(64'hB, 64'd0, 64'd0, 64'd0, 64'd0);
        step_sample();
        $display("bp offer B in_ready=%0b out=%0h", in_ready, out_data);
        chk("bp_b_ready", in_ready, 0);
        chk("bp_b_hold", out_data, 64'hA);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            set_lanes(64'hC, 64'd0, 64'd0, 64'd0, 64'd0);
            step_sample();
            $display("bp offer C in_ready=%0b out=%0h", in_ready, out_data);
            chk("bp_c_ready", in_ready, 0);
            chk("bp_c_hold", out_data, 64'hA);
            chk("bp_c_valid", out_valid, 1);
        end
        @(negedge clk);
        out_ready = 1;
        step_sample();
        $display("bp release out=%0h", out_data);
        chk("bp_out_b", out_data, 64'hB);
        chk("bp_ready_back", in_ready, 1);
        step_sample();
        $display("bp release out=%0h", out_data);
        chk("bp_out_c", out_data, 64'hC);
        chk("bp_out_c_valid", out_valid, 1);
        @(negedge clk);
        in_valid = 0;
        step_sample();
        chk("bp_empty", out_valid, 0);

        // flags
        @(negedge clk);
        in_valid = 1; sel = 0; set_flags = 1; carry_in = 1; ovf_in = 0;
        set_lanes(64'd0, 64'd7, 64'd7, 64'd7, 64'd7);
        step_sample();
        $display("flags zero nzcv=%0b%0b%0b%0b", flag_n, flag_z, flag_c, flag_v);
        chk_flags("flags_zero", 4'b0110);
        @(negedge clk);
        ovf_in = 1;
        set_lanes(64'h8000_0000_0000_0000, 64'd0, 64'd0, 64'd0, 64'd0);
        step_sample();
        $display("flags neg nzcv=%0b%0b%0b%0b", flag_n, flag_z, flag_c, flag_v);
        chk_flags("flags_neg", 4'b1011);
        @(negedge clk);
        set_flags = 0; carry_in = 0; ovf_in = 0;
        set_lanes(64'd0, 64'd0, 64'd0, 64'd0, 64'd0);
        step_sample();
        $display("flags hold nzcv=%0b%0b%0b%0b", flag_n, flag_z, flag_c, flag_v);
        chk_flags("flags_hold", 4'b1011);

        // err suppression
        @(negedge clk);
        sel = 6; set_flags = 1; carry_in = 1; ovf_in = 0;
        step_sample();
        $display("err sel=6 data=%0h err=%0b", out_data, out_sel_err);
        chk_flags("err_flags", 4'b1011);
        chk("err_data", out_data, 0);
        chk("err_bit", out_sel_err, 1);

        // reset mid-operation with both entries full
        @(negedge clk);
        set_flags = 0; sel = 0; out_ready = 0;
        set_lanes(64'h11, 64'd0, 64'd0, 64'd0, 64'd0);
        step_sample();
        step_sample();
        chk("mr_full", in_ready, 0);
        #2;
        reset_n = 1'b0;
        #1;
        $display("midreset valid=%0b data=%0h ready=%0b", out_valid, out_data, in_ready);
        chk("mr_valid", out_valid, 0);
        chk("mr_data", out_data, 0);
        chk("mr_err", out_sel_err, 0);
        chk_flags("mr_flags", 4'b0000);
        @(negedge clk);
        in_valid = 0; out_ready = 1;
        reset_n = 1'b1;
        step_sample();
        chk("mr_ready", in_ready, 1);
        chk("mr_empty", out_valid, 0);

        // parameter variant
        for (int i = 0; i < 8; i++) in_data16[i*16 +: 16] = 16'(10 + i);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            in_valid16 = 1; sel16 = 3'(i);
            step_sample();
            $display("w16 sel=%0d data=%0d err=%0b", i, out_data16, out_sel_err16);
            chk("w16_data", {48'd0, out_data16}, 64'(10 + i));
            chk("w16_err", out_sel_err16, 0);
            chk("w16_valid", out_valid16, 1);
        end
        @(negedge clk);
        in_valid16 = 0;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
